// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, ALU op codes,
// sequencer state encoding, instruction classes and the control-word bundle
// that the sequencer decodes each cycle.
package cpu_defs_pkg;

  localparam int unsigned OpW = 5;

  // Opcodes (IR[31:27])
  localparam logic [OpW-1:0] OpLd   = 5'b00000;
  localparam logic [OpW-1:0] OpSt   = 5'b00010;
  localparam logic [OpW-1:0] OpAdd  = 5'b00011;
  localparam logic [OpW-1:0] OpSub  = 5'b00100;
  localparam logic [OpW-1:0] OpAnd  = 5'b00101;
  localparam logic [OpW-1:0] OpOr   = 5'b00110;
  localparam logic [OpW-1:0] OpAddi = 5'b01100;
  localparam logic [OpW-1:0] OpAndi = 5'b01101;
  localparam logic [OpW-1:0] OpOri  = 5'b01110;
  localparam logic [OpW-1:0] OpBrx  = 5'b10010;
  localparam logic [OpW-1:0] OpJr   = 5'b10100;
  localparam logic [OpW-1:0] OpMfhi = 5'b11000;
  localparam logic [OpW-1:0] OpMflo = 5'b11001;
  localparam logic [OpW-1:0] OpNop  = 5'b11010;
  localparam logic [OpW-1:0] OpHalt = 5'b11011;

  // ALU operation codes driven on `operation`
  localparam logic [OpW-1:0] AluNone = 5'b00000;
  localparam logic [OpW-1:0] AluAdd  = 5'b00011;
  localparam logic [OpW-1:0] AluSub  = 5'b00100;
  localparam logic [OpW-1:0] AluAnd  = 5'b00101;
  localparam logic [OpW-1:0] AluOr   = 5'b00110;

  typedef enum logic [3:0] {
    StReset = 4'd0,
    StT0    = 4'd1,
    StT1    = 4'd2,
    StT2    = 4'd3,
    StT3    = 4'd4,
    StT4    = 4'd5,
    StT5    = 4'd6,
    StT6    = 4'd7,
    StT7    = 4'd8,
    StHalt  = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    ClsRtype,
    ClsImm,
    ClsLd,
    ClsSt,
    ClsBr,
    ClsJr,
    ClsMfhi,
    ClsMflo,
    ClsNop,
    ClsHalt
  } instr_class_e;

  // One bit per datapath control input; zero means idle.
  typedef struct packed {
    logic pc_out;
    logic zlow_out;
    logic zhigh_out;
    logic mdr_out;
    logic hi_out;
    logic lo_out;
    logic c_out;
    logic inport_out;
    logic mar_in;
    logic z_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic inc_pc;
    logic read;
    logic write;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic con_in;
    logic run;
    logic [OpW-1:0] operation;
  } ctrl_t;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier.
//   opcode_i : IR[31:27]
//   class_o  : instruction class selecting the execute sequence
//   alu_op_o : ALU operation used by that class (0 when the class uses none)
// Undefined opcodes classify as nop.
module instr_class_decode
  import cpu_defs_pkg::*;
#(
  parameter int unsigned OPW = 5
) (
  input  logic [OPW-1:0] opcode_i,
  output instr_class_e   class_o,
  output logic [OPW-1:0] alu_op_o
);

  always_comb begin
    class_o  = ClsNop;
    alu_op_o = AluNone;
    case (opcode_i)
      OpAdd, OpSub, OpAnd, OpOr: begin
        class_o  = ClsRtype;
        alu_op_o = opcode_i;
      end
      OpAddi: begin
        class_o  = ClsImm;
        alu_op_o = AluAdd;
      end
      OpAndi: begin
        class_o  = ClsImm;
        alu_op_o = AluAnd;
      end
      OpOri: begin
        class_o  = ClsImm;
        alu_op_o = AluOr;
      end
      OpLd: begin
        class_o  = ClsLd;
        alu_op_o = AluAdd;
      end
      OpSt: begin
        class_o  = ClsSt;
        alu_op_o = AluAdd;
      end
      OpBrx: begin
        class_o  = ClsBr;
        alu_op_o = AluAdd;
      end
      OpJr:    class_o = ClsJr;
      OpMfhi:  class_o = ClsMfhi;
      OpMflo:  class_o = ClsMflo;
      OpNop:   class_o = ClsNop;
      OpHalt:  class_o = ClsHalt;
      default: class_o = ClsNop;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control unit for `datapath`.
// Inputs : Clock, Reset (async, active-high), IR (latched instruction),
//          CON_out (branch condition flag).
// Outputs: bus source selects, register load enables, PC/memory strobes,
//          register-file selects, CON_in, ALU `operation`, and Run.
// One T-state per clock; outputs are Moore-decoded from the state register
// and the opcode field.
module control_sequencer
  import cpu_defs_pkg::*;
#(
  parameter int unsigned OPW = 5
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [31:0]    IR,
  input  logic           CON_out,
  output logic           PCout,
  output logic           Zlowout,
  output logic           ZHighout,
  output logic           MDRout,
  output logic           HIout,
  output logic           LOout,
  output logic           Cout,
  output logic           InPortout,
  output logic           MARin,
  output logic           Zin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           IncPC,
  output logic           Read,
  output logic           Write,
  output logic           GRA,
  output logic           GRB,
  output logic           GRC,
  output logic           Rin,
  output logic           Rout,
  output logic           BAout,
  output logic           CON_in,
  output logic [OPW-1:0] operation,
  output logic           Run
);

  state_e         state_q, state_d;
  instr_class_e   cls;
  logic [OPW-1:0] alu_op;
  ctrl_t          ctrl;

  // Only the opcode field matters to control; operand fields are datapath's.
  logic unused_ir;
  assign unused_ir = ^IR[31-OPW:0];

  instr_class_decode #(
    .OPW (OPW)
  ) u_decode (
    .opcode_i (IR[31:32-OPW]),
    .class_o  (cls),
    .alu_op_o (alu_op)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetch steps (T0-T2) never look at IR: it is only loaded at the end of T2.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      StReset: state_d = StT0;
      StT0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.z_in   = 1'b1;
        state_d     = StT1;
      end
      StT1: begin
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = 1'b1;
        ctrl.read     = 1'b1;
        ctrl.mdr_in   = 1'b1;
        state_d       = StT2;
      end
      StT2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        state_d      = StT3;
      end
      StT3: begin
        state_d = StT4;
        case (cls)
          ClsRtype, ClsImm: begin
            ctrl.grb   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.y_in  = 1'b1;
          end
          ClsLd, ClsSt: begin
            ctrl.grb    = 1'b1;
            ctrl.ba_out = 1'b1;
            ctrl.y_in   = 1'b1;
          end
          ClsBr: begin
            ctrl.gra    = 1'b1;
            ctrl.r_out  = 1'b1;
            ctrl.con_in = 1'b1;
          end
          ClsJr: begin
            ctrl.gra   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.pc_in = 1'b1;
            state_d    = StT0;
          end
          ClsMfhi: begin
            ctrl.hi_out = 1'b1;
            ctrl.gra    = 1'b1;
            ctrl.r_in   = 1'b1;
            state_d     = StT0;
          end
          ClsMflo: begin
            ctrl.lo_out = 1'b1;
            ctrl.gra    = 1'b1;
            ctrl.r_in   = 1'b1;
            state_d     = StT0;
          end
          ClsHalt: state_d = StHalt;
          default: state_d = StT0;
        endcase
      end
      StT4: begin
        state_d = StT5;
        case (cls)
          ClsRtype: begin
            ctrl.grc       = 1'b1;
            ctrl.r_out     = 1'b1;
            ctrl.z_in      = 1'b1;
            ctrl.operation = alu_op;
          end
          ClsImm, ClsLd, ClsSt: begin
            ctrl.c_out     = 1'b1;
            ctrl.z_in      = 1'b1;
            ctrl.operation = alu_op;
          end
          ClsBr: begin
            ctrl.pc_out = 1'b1;
            ctrl.y_in   = 1'b1;
          end
          default: state_d = StT0;
        endcase
      end
      StT5: begin
        state_d = StT0;
        case (cls)
          ClsRtype, ClsImm: begin
            ctrl.zlow_out = 1'b1;
            ctrl.gra      = 1'b1;
            ctrl.r_in     = 1'b1;
          end
          ClsLd, ClsSt: begin
            ctrl.zlow_out = 1'b1;
            ctrl.mar_in   = 1'b1;
            state_d       = StT6;
          end
          ClsBr: begin
            ctrl.c_out     = 1'b1;
            ctrl.z_in      = 1'b1;
            ctrl.operation = alu_op;
            state_d        = StT6;
          end
          default: state_d = StT0;
        endcase
      end
      StT6: begin
        state_d = StT0;
        case (cls)
          ClsLd: begin
            ctrl.read   = 1'b1;
            ctrl.mdr_in = 1'b1;
            state_d     = StT7;
          end
          ClsSt: begin
            ctrl.gra    = 1'b1;
            ctrl.r_out  = 1'b1;
            ctrl.mdr_in = 1'b1;
            state_d     = StT7;
          end
          ClsBr: begin
            // CON was loaded in T3; the taken target is already in Z.
            ctrl.zlow_out = CON_out;
            ctrl.pc_in    = CON_out;
          end
          default: state_d = StT0;
        endcase
      end
      StT7: begin
        state_d = StT0;
        case (cls)
          ClsLd: begin
            ctrl.mdr_out = 1'b1;
            ctrl.gra     = 1'b1;
            ctrl.r_in    = 1'b1;
          end
          ClsSt:   ctrl.write = 1'b1;
          default: state_d = StT0;
        endcase
      end
      StHalt:  state_d = StHalt;
      // Unused encodings fall back to a clean restart.
      default: state_d = StReset;
    endcase
    ctrl.run = (state_q >= StT0) && (state_q <= StT7);
  end

  assign PCout     = ctrl.pc_out;
  assign Zlowout   = ctrl.zlow_out;
  assign ZHighout  = ctrl.zhigh_out;
  assign MDRout    = ctrl.mdr_out;
  assign HIout     = ctrl.hi_out;
  assign LOout     = ctrl.lo_out;
  assign Cout      = ctrl.c_out;
  assign InPortout = ctrl.inport_out;
  assign MARin     = ctrl.mar_in;
  assign Zin       = ctrl.z_in;
  assign PCin      = ctrl.pc_in;
  assign MDRin     = ctrl.mdr_in;
  assign IRin      = ctrl.ir_in;
  assign Yin       = ctrl.y_in;
  assign IncPC     = ctrl.inc_pc;
  assign Read      = ctrl.read;
  assign Write     = ctrl.write;
  assign GRA       = ctrl.gra;
  assign GRB       = ctrl.grb;
  assign GRC       = ctrl.grc;
  assign Rin       = ctrl.r_in;
  assign Rout      = ctrl.r_out;
  assign BAout     = ctrl.ba_out;
  assign CON_in    = ctrl.con_in;
  assign operation = ctrl.operation;
  assign Run       = ctrl.run;

endmodule
